// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam int STARVE_LIM_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU fetch/data ports plus the memory-side port; slave = arbiter, master = environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Data-priority grant selection with a saturating starvation counter for fetch.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_gnt_en,
  input  logic       i_fetch_req,
  input  logic       i_data_req,
  output logic       o_gnt_valid,
  output arb_owner_t o_gnt_owner
);
  localparam int SW = cnt_width(STARVE_LIM);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [SW-1:0] r_starve_cnt;
  logic          w_pick_d;

  always_comb begin
    w_pick_d    = i_data_req && (!i_fetch_req || (r_starve_cnt < LIM));
    o_gnt_valid = i_gnt_en && (i_data_req || i_fetch_req);
    o_gnt_owner = w_pick_d ? OWN_D : OWN_I;
  end

  // Only D grants that bypass a waiting fetch count toward starvation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (o_gnt_valid) begin
      if (w_pick_d && i_fetch_req) begin
        if (r_starve_cnt != LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D) with a hung-access watchdog.
// States: IDLE grant when a request is present | BUSY m_req held, watchdog running | RESP one-cycle ack to owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BE_W        = DATA_W / 8,
  parameter int STARVE_LIM  = STARVE_LIM_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);
  localparam int TW = cnt_width(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  arb_state_t        r_state, w_state_nxt;
  arb_owner_t        r_owner, w_gnt_owner;
  logic              w_gnt_valid;
  logic              w_done, w_tmo;
  logic [TW-1:0]     r_tmo_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [BE_W-1:0]   r_be;
  logic              r_we;
  logic              r_err;

  mem_arb_grant #(.STARVE_LIM(STARVE_LIM)) u_grant (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_gnt_en    (r_state == IDLE),
    .i_fetch_req (bus.i_req),
    .i_data_req  (bus.d_req),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_owner (w_gnt_owner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // m_ack takes precedence over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: if (w_gnt_valid) w_state_nxt = BUSY;
      BUSY: begin
        if (bus.m_ack) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= OWN_I;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_gnt_valid) begin
        r_owner <= w_gnt_owner;
        if (w_gnt_owner == OWN_D) begin
          r_addr  <= bus.d_addr;
          r_wdata <= bus.d_wdata;
          r_be    <= bus.d_be;
          r_we    <= bus.d_we;
        end else begin
          r_addr  <= bus.i_addr;
          r_wdata <= '0;
          r_be    <= '1;
          r_we    <= 1'b0;
        end
      end
      if (r_state == BUSY) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                 r_tmo_cnt <= '0;
      if (w_done) begin
        r_rdata <= bus.m_rdata;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.m_req   = (r_state == BUSY);
  assign bus.m_we    = r_we;
  assign bus.m_addr  = r_addr;
  assign bus.m_wdata = r_wdata;
  assign bus.m_be    = r_be;

  assign bus.i_ack   = (r_state == RESP) && (r_owner == OWN_I);
  assign bus.d_ack   = (r_state == RESP) && (r_owner == OWN_D);
  assign bus.i_rdata = bus.i_ack ? r_rdata : '0;
  assign bus.d_rdata = bus.d_ack ? r_rdata : '0;
  assign bus.i_err   = bus.i_ack & r_err;
  assign bus.d_err   = bus.d_ack & r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small wait-state memory responder.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic        mem_auto;
  logic        force_ack;
  int          mem_wait;
  int          busy_cyc = 0;
  logic [31:0] mem_rdata;

  always @(posedge clk) busy_cyc <= bus.m_req ? busy_cyc + 1 : 0;
  assign bus.m_ack   = force_ack | (mem_auto & bus.m_req & (busy_cyc == mem_wait));
  assign bus.m_rdata = mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit want_d, output int cyc, output logic other_seen);
    cyc = 0;
    other_seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (want_d ? bus.i_ack : bus.d_ack) other_seen = 1'b1;
      if (want_d ? bus.d_ack : bus.i_ack) return;
    end
    chk("ack_budget", 32'd0, 32'd1);
  endtask

  task automatic next_grant(output logic got_i);
    got_i = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        got_i = bus.i_ack;
        return;
      end
    end
    chk("grant_budget", 32'd0, 32'd1);
  endtask

  int          cyc;
  int          mreq_cyc;
  logic        other;
  logic        got_i;
  logic [9:0]  exp_seq;
  logic [4:0]  exp_seq5;

  initial begin
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    mem_auto = 1; force_ack = 0; mem_wait = 0; mem_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_i_ack", bus.i_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    rst_n = 1;
    @(negedge clk);

    // stray m_ack while idle
    force_ack = 1;
    repeat (2) @(negedge clk);
    chk("stray_m_req", bus.m_req, 0);
    chk("stray_acks", {bus.i_ack, bus.d_ack}, 0);
    force_ack = 0;
    @(negedge clk);

    // single fetch, zero-wait memory
    mem_rdata = 32'hDEADBEEF;
    bus.i_addr = 32'h10;
    bus.i_req = 1;
    @(posedge clk); @(negedge clk);
    chk("fetch_m_req", bus.m_req, 1);
    chk("fetch_m_addr", bus.m_addr, 32'h10);
    chk("fetch_m_we", bus.m_we, 0);
    chk("fetch_m_be", bus.m_be, 4'hF);
    wait_ack(1'b0, cyc, other);
    chk("fetch_latency", cyc, 1);
    chk("fetch_rdata", bus.i_rdata, 32'hDEADBEEF);
    chk("fetch_err", bus.i_err, 0);
    chk("fetch_no_d_ack", other, 0);
    bus.i_req = 0;

    // half-word store, two wait states
    @(negedge clk);
    mem_wait = 2; mem_rdata = 32'h0;
    bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h0000ABCD; bus.d_be = 4'b0011;
    bus.d_req = 1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("st_m_req_c%0d", k), bus.m_req, 1);
      chk($sformatf("st_m_we_c%0d", k), bus.m_we, 1);
      chk($sformatf("st_m_addr_c%0d", k), bus.m_addr, 32'h20);
      chk($sformatf("st_m_be_c%0d", k), bus.m_be, 4'b0011);
      chk($sformatf("st_m_wdata_c%0d", k), bus.m_wdata, 32'h0000ABCD);
      chk($sformatf("st_d_ack_c%0d", k), bus.d_ack, 0);
    end
    @(posedge clk); @(negedge clk);
    chk("st_d_ack", bus.d_ack, 1);
    chk("st_d_err", bus.d_err, 0);
    chk("st_m_req_drop", bus.m_req, 0);
    bus.d_req = 0; bus.d_we = 0;
    mem_wait = 0;
    @(negedge clk);
    chk("st_ack_pulse", bus.d_ack, 0);

    // contention: both held, first D, fetch every fifth grant
    bus.i_req = 1; bus.d_req = 1;
    exp_seq = 10'b10_0001_0000;
    for (int k = 0; k < 10; k++) begin
      next_grant(got_i);
      chk($sformatf("grant%0d_is_i", k), got_i, exp_seq[k]);
    end
    bus.i_req = 0; bus.d_req = 0;
    @(negedge clk);

    // watchdog on a hung load
    mem_auto = 0; mem_rdata = 32'hCAFEF00D;
    bus.d_addr = 32'h30;
    bus.d_req = 1;
    mreq_cyc = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); @(negedge clk);
      if (bus.m_req) mreq_cyc++;
      if (bus.d_ack) break;
    end
    chk("tmo_m_req_cycles", mreq_cyc, 64);
    chk("tmo_d_ack", bus.d_ack, 1);
    chk("tmo_d_err", bus.d_err, 1);
    chk("tmo_d_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    mem_auto = 1;
    @(negedge clk);
    mem_rdata = 32'h12345678;
    bus.i_addr = 32'h44;
    bus.i_req = 1;
    wait_ack(1'b0, cyc, other);
    chk("post_tmo_latency", cyc, 2);
    chk("post_tmo_rdata", bus.i_rdata, 32'h12345678);
    chk("post_tmo_err", bus.i_err, 0);
    bus.i_req = 0;
    @(negedge clk);

    // reset in the middle of a hung D access that bumped the starve count
    mem_auto = 0;
    bus.i_req = 1; bus.d_req = 1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("mid_m_req", bus.m_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_m_req", bus.m_req, 0);
    chk("rst_mid_acks", {bus.i_ack, bus.d_ack}, 0);
    chk("rst_mid_errs", {bus.i_err, bus.d_err}, 0);
    @(negedge clk);
    mem_auto = 1;
    rst_n = 1;
    exp_seq5 = 5'b10000;
    for (int k = 0; k < 5; k++) begin
      next_grant(got_i);
      chk($sformatf("post_rst_grant%0d_is_i", k), got_i, exp_seq5[k]);
    end
    bus.i_req = 0; bus.d_req = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the CPU instruction-fetch port (I) and the load/store port (D), which serves ldl/ldh/stl/sth.
- Accepts one transaction at a time, forwards it to the memory port, and returns read data and a status pulse to the winning requester.
- Sits between the CPU core and the memory model/RAM.
- Arbitration is data-priority with a starvation guard for fetch.
- A watchdog converts a hung memory access into an error response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BE_W, DATA_W/8, byte-enable width (stl/sth select half via be).
- STARVE_LIM, 4, consecutive D grants allowed while I is pending.
- TIMEOUT_CYC, 64, max cycles waiting for m_ack.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_ack  out  1  one-cycle completion pulse to fetch.
- i_rdata  out  DATA_W  fetched word, valid with i_ack.
- i_err  out  1  timeout flag, valid with i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  BE_W  byte enables.
- d_ack  out  1  one-cycle completion pulse to data port.
- d_rdata  out  DATA_W  load data, valid with d_ack.
- d_err  out  1  timeout flag, valid with d_ack.
- m_req  out  1  memory request; held until m_ack or timeout.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_be  out  BE_W  memory byte enables.
- m_ack  in  1  memory completion pulse.
- m_rdata  in  DATA_W  memory read data, valid with m_ack.

Behaviour:
- Reset (async, rst_n=0): every output is 0; state is IDLE; starve_cnt=0; tmo_cnt=0. Takes effect immediately, including mid-transaction. No response is issued for the aborted transaction.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Grant rule: D wins if d_req and (not i_req or starve_cnt < STARVE_LIM). Otherwise I wins if i_req.
  - On grant: register owner, addr, we, wdata, be. For I grants, force we=0 and be all-ones.
  - Next state is BUSY; m_req rises the cycle after the grant edge.
- starve_cnt:
  - Increments on a D grant while i_req=1, saturating at STARVE_LIM.
  - Clears on any I grant, and on any D grant while i_req=0.
- BUSY:
  - m_req=1 and m_* are stable for the whole state.
  - tmo_cnt increments each cycle.
  - On m_ack: capture m_rdata, set err=0, drop m_req next cycle, go to RESP.
  - If tmo_cnt reaches TIMEOUT_CYC-1 without m_ack: drop m_req, set rdata=0 and err=1, go to RESP.
  - m_ack and timeout in the same cycle: m_ack wins, err=0.
- RESP (1 cycle):
  - Owner's ack=1 with rdata/err; the other port's ack=0.
  - tmo_cnt clears. Next state is IDLE.
- Requester rule: drop req (or present a new request) on the edge ending the ack cycle. The IDLE cycle after RESP samples the updated req values.
- Latency:
  - Grant edge at cycle 0; m_req high from cycle 1.
  - m_ack in cycle k (k≥1) gives the requester ack in cycle k+1.
  - Minimum request-to-ack is 3 cycles with a zero-wait memory (m_ack in cycle 1).
- Ignored inputs:
  - m_ack outside BUSY is ignored.
  - Requests arriving during BUSY/RESP wait in IDLE; they are not dropped.
- Outputs i_rdata/d_rdata/err are registered; they are 0 when ack=0.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum {IDLE, BUSY, RESP} arb_state_t.
  - typedef enum {OWN_I, OWN_D} arb_owner_t.
  - Default constants for STARVE_LIM and TIMEOUT_CYC.
- One sub-module, mem_arb_grant: combinational grant selection plus the starvation counter register. The top-level FSM, datapath registers and timeout live in mem_port_arbiter.

Test Plan:
- Single fetch: i_req, i_addr=0x10; memory returns m_rdata=0xDEADBEEF one cycle after m_req -> i_ack=1 with i_rdata=0xDEADBEEF, i_err=0, 3 cycles after the request; d_ack never asserted.
- Store half: d_req, d_we=1, d_addr=0x20, d_wdata=0x0000ABCD, d_be=0b0011 -> m_we=1, m_addr=0x20, m_be=0b0011 stable until m_ack; d_ack one cycle after m_ack.
- Contention/starvation: i_req and d_req held continuously, zero-wait memory, STARVE_LIM=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Simultaneous first request with i_req=0 previously (starve_cnt=0) -> D granted first.
- Timeout: d_req with m_ack never asserted, TIMEOUT_CYC=64 -> m_req drops after 64 BUSY cycles; d_ack=1, d_err=1, d_rdata=0; next request is served normally.
- Reset mid-BUSY: rst_n=0 while m_req=1 -> m_req, acks and errs go to 0 immediately. After release, a pending i_req is granted from IDLE with starve_cnt=0.
